cmos_pattern_gen: RTL and testbench
===================================

# cmos_pattern_gen

Synthetic camera-side source for the pixel-stream interface consumed by the binarisation front end. Drives `m_vs`, `m_href`, `m_wr_en` and `m_data` with the same framing as the sensor path: 480-pixel active lines, RGB565 data, one valid pixel per `m_wr_en` strobe. Selectable test patterns exercise the 112×112 ROI binariser and the downstream recogniser without a sensor attached. Sits in place of the sensor capture stage, in the `m_pclk` domain.

## Interface
- `H_ACTIVE`, 480: valid pixels per line.
- `V_ACTIVE`, 272: active lines per frame.
- `H_BLANK`, 40: clocks with `m_href` low after each active line.
- `WR_EVERY`, 2: clocks per pixel slot; `m_wr_en` is high on the first clock of each slot. Legal values are 1 to 4.
- `V_SYNC_LINES`, 2; `V_BACK_LINES`, 3; `V_FRONT_LINES`, 2: vertical intervals, in line periods.
- `m_pclk` input, 1 bit: pixel clock. This is the only clock.
- `s_rst_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: run frames continuously while high.
- `pat_sel` input, 2 bits: 0 = colour bars, 1 = grey ramp, 2 = checkerboard, 3 = ROI box.
- `m_data` output, 16 bits: RGB565 pixel. Meaningful only when `m_wr_en` is 1; 0 otherwise.
- `m_vs` output, 1 bit: vertical sync, active high.
- `m_href` output, 1 bit: line valid.
- `m_wr_en` output, 1 bit: pixel strobe. Only ever high while `m_href` is 1.
- `frame_cnt` output, 8 bits: number of completed frames. Wraps from 255 to 0.

## Operation
- One line period is L = H_ACTIVE*WR_EVERY + H_BLANK clocks.
- FSM states and transitions:
  - IDLE: go to VSYNC when `enable` is 1.
  - VSYNC: `m_vs` = 1 for V_SYNC_LINES*L clocks, then go to VBACK.
  - VBACK: all outputs low for V_BACK_LINES*L clocks, then go to ACTIVE.
  - ACTIVE: `m_href` = 1 for H_ACTIVE*WR_EVERY clocks, then go to HBLANK.
  - HBLANK: `m_href` = 0 for H_BLANK clocks. Go back to ACTIVE if lines remain, otherwise go to VFRONT.
  - VFRONT: lasts V_FRONT_LINES*L clocks. At exit `frame_cnt` increments; go to VSYNC if `enable` is 1, else IDLE.
- Counters: `col` runs 0 to H_ACTIVE-1 and advances on each `m_wr_en`. `row` runs 0 to V_ACTIVE-1 and advances at the end of each line. A slot-phase counter runs 0 to WR_EVERY-1.
- `pat_sel` is sampled on entry to VSYNC and held for the whole frame.
- Patterns, computed from (col, row):
  - Bars: 8 bars of H_ACTIVE/8 pixels each, in the order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Ramp: v = col[8:1]; `m_data` = {v[7:3], v[7:2], v[7:3]}.
  - Checkerboard: (col[4] ^ row[4]) ? FFFF : 0000.
  - Box: FFFF when 184 ≤ col ≤ 295 and 80 ≤ row ≤ 191, else 0000.
- Boundary conditions:
  - `enable` dropping mid-frame: the current frame completes unchanged, then the FSM goes to IDLE.
  - `enable` 0 throughout: stay in IDLE with all outputs 0.
  - `s_rst_n` asserted at any point: outputs and counters go to 0 immediately and the FSM goes to IDLE, with no partial-line completion.
  - WR_EVERY = 1: `m_wr_en` equals `m_href`.

## Timing
- All outputs are registered.
- Reset values: every output is 0 and `frame_cnt` is 0.
- From the first rising edge with `enable` = 1 in IDLE, `m_vs` rises on the next cycle.
- The first `m_href` rise occurs (V_SYNC_LINES + V_BACK_LINES)*L clocks after the `m_vs` rise.
- `m_data` is valid in the same cycle as its `m_wr_en`. The pixel for col c is presented on the c-th strobe of the line.
- `m_href` falls on the clock after the last slot of a line. It stays low for exactly H_BLANK clocks between lines.
- Each active line carries exactly H_ACTIVE strobes; each frame carries exactly V_ACTIVE lines.
- Frame period = (V_SYNC_LINES + V_BACK_LINES + V_ACTIVE + V_FRONT_LINES)*L clocks, with no extra gap while `enable` stays 1.

## Structure
- Shared package `cmos_stream_pkg` holds:
  - the pattern codes (PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_BOX);
  - the RGB565 colour constants;
  - the ROI bounds (184, 295, 80, 191);
  - the default timing values.
- One sub-module, `cmos_pattern_pixel`: purely combinational mapping of (pat, col, row) to RGB565. The registered output stage stays in the top module.

## Test plan
- Reset and idle: hold `s_rst_n` = 0, then release with `enable` = 0. Expect all outputs 0 for 10,000 clocks and `frame_cnt` = 0.
- Frame framing, default parameters (L = 1000):
  - `m_vs` high for 2000 clocks;
  - first `m_href` 3000 clocks after `m_vs` falls;
  - 480 strobes per line, 272 lines;
  - `frame_cnt` = 1 after 279,000 clocks.
- Bars: pixel (0,0) = FFFF, (60,0) = FFE0, (419,5) = 001F, (479,5) = 0000.
- Box checked through the binariser at threshold 128:
  - pixels (184,80) and (295,191) are FFFF, (183,80) is 0000;
  - binariser `bin_data_vld` count per frame = 12,544.
- Mid-frame changes: toggle `pat_sel` and drop `enable` at row 100. The rest of the frame keeps the old pattern and timing, the FSM then goes to IDLE, and `frame_cnt` increments once.
- Asynchronous reset mid-line at col 250: outputs go to 0 immediately. After release with `enable` = 1, a fresh VSYNC begins and `frame_cnt` = 0.

Source files
------------

// File: rtl/cmos_stream_pkg.sv
// rtl/cmos_stream_pkg.sv - shared codes, colours, ROI bounds and default timing for the pattern source
package cmos_stream_pkg;

    // Counter widths for col/row and the pixel-slot phase (WR_EVERY <= 4).
    localparam int CW = 10;
    localparam int PW = 2;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BOX   = 2'd3
    } pat_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } state_e;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // 112x112 window seen by the ROI binariser.
    localparam logic [CW-1:0] ROI_COL_MIN = 10'd184;
    localparam logic [CW-1:0] ROI_COL_MAX = 10'd295;
    localparam logic [CW-1:0] ROI_ROW_MIN = 10'd80;
    localparam logic [CW-1:0] ROI_ROW_MAX = 10'd191;

    localparam int DEF_H_ACTIVE      = 480;
    localparam int DEF_V_ACTIVE      = 272;
    localparam int DEF_H_BLANK       = 40;
    localparam int DEF_WR_EVERY      = 2;
    localparam int DEF_V_SYNC_LINES  = 2;
    localparam int DEF_V_BACK_LINES  = 3;
    localparam int DEF_V_FRONT_LINES = 2;

endpackage

// File: rtl/cmos_pattern_pixel.sv
// rtl/cmos_pattern_pixel.sv - combinational (pattern, col, row) to RGB565 mapping
// Ports: pat selects the pattern; col/row give the pixel position; rgb is the RGB565 colour.
module cmos_pattern_pixel
    import cmos_stream_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  pat_e          pat,
    input  logic [CW-1:0] col,
    input  logic [CW-1:0] row,
    output logic [15:0]   rgb
);

    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);

    logic [CW-1:0] bar;
    logic [7:0]    v;
    logic          in_box;

    always_comb begin
        bar    = col / BAR_W;
        v      = col[8:1];
        in_box = (col >= ROI_COL_MIN) && (col <= ROI_COL_MAX) &&
                 (row >= ROI_ROW_MIN) && (row <= ROI_ROW_MAX);
        rgb    = RGB_BLACK;
        case (pat)
            PAT_BARS: begin
                // Any leftover columns past the eighth bar stay black.
                case (bar)
                    10'd0:   rgb = RGB_WHITE;
                    10'd1:   rgb = RGB_YELLOW;
                    10'd2:   rgb = RGB_CYAN;
                    10'd3:   rgb = RGB_GREEN;
                    10'd4:   rgb = RGB_MAGENTA;
                    10'd5:   rgb = RGB_RED;
                    10'd6:   rgb = RGB_BLUE;
                    default: rgb = RGB_BLACK;
                endcase
            end
            PAT_RAMP:  rgb = {v[7:3], v[7:2], v[7:3]};
            PAT_CHECK: rgb = (col[4] ^ row[4]) ? RGB_WHITE : RGB_BLACK;
            default:   rgb = in_box ? RGB_WHITE : RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/cmos_pattern_gen.sv
// rtl/cmos_pattern_gen.sv - synthetic sensor-style RGB565 frame source with selectable patterns
// Ports: m_pclk pixel clock, s_rst_n async active-low reset, enable runs frames continuously,
//        pat_sel pattern (latched per frame); m_vs/m_href/m_wr_en/m_data pixel stream,
//        frame_cnt completed-frame count.
module cmos_pattern_gen
    import cmos_stream_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int H_BLANK       = DEF_H_BLANK,
    parameter int WR_EVERY      = DEF_WR_EVERY,
    parameter int V_SYNC_LINES  = DEF_V_SYNC_LINES,
    parameter int V_BACK_LINES  = DEF_V_BACK_LINES,
    parameter int V_FRONT_LINES = DEF_V_FRONT_LINES
) (
    input  logic        m_pclk,
    input  logic        s_rst_n,
    input  logic        enable,
    input  logic [1:0]  pat_sel,
    output logic [15:0] m_data,
    output logic        m_vs,
    output logic        m_href,
    output logic        m_wr_en,
    output logic [7:0]  frame_cnt
);

    localparam int L     = H_ACTIVE * WR_EVERY + H_BLANK;
    localparam int T_MAX = (V_SYNC_LINES + V_BACK_LINES + V_FRONT_LINES) * L;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] T_VSYNC  = TW'(V_SYNC_LINES * L - 1);
    localparam logic [TW-1:0] T_VBACK  = TW'(V_BACK_LINES * L - 1);
    localparam logic [TW-1:0] T_VFRONT = TW'(V_FRONT_LINES * L - 1);
    localparam logic [TW-1:0] T_HBLANK = TW'(H_BLANK - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(WR_EVERY - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(V_ACTIVE - 1);

    state_e        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [CW-1:0] col, col_nxt, row, row_nxt;
    logic [PW-1:0] phase, phase_nxt;
    pat_e          pat_q, pat_nxt;
    logic [7:0]    frame_nxt;
    logic          vs_nxt, href_nxt, wr_nxt;
    logic [15:0]   pix, data_nxt;

    // The pixel is looked up from the next-cycle position so that the
    // registered m_data lines up with the registered m_wr_en.
    cmos_pattern_pixel #(.H_ACTIVE(H_ACTIVE)) u_pixel (
        .pat (pat_nxt),
        .col (col_nxt),
        .row (row_nxt),
        .rgb (pix)
    );

    always_ff @(posedge m_pclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            col       <= '0;
            row       <= '0;
            phase     <= '0;
            pat_q     <= PAT_BARS;
            frame_cnt <= '0;
            m_vs      <= 1'b0;
            m_href    <= 1'b0;
            m_wr_en   <= 1'b0;
            m_data    <= '0;
        end else begin
            state     <= state_nxt;
            tmr       <= tmr_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            phase     <= phase_nxt;
            pat_q     <= pat_nxt;
            frame_cnt <= frame_nxt;
            m_vs      <= vs_nxt;
            m_href    <= href_nxt;
            m_wr_en   <= wr_nxt;
            m_data    <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr + TW'(1);
        col_nxt   = col;
        row_nxt   = row;
        phase_nxt = phase;
        pat_nxt   = pat_q;
        frame_nxt = frame_cnt;
        case (state)
            ST_IDLE: begin
                tmr_nxt = '0;
                if (enable) begin
                    state_nxt = ST_VSYNC;
                    pat_nxt   = pat_e'(pat_sel);
                end
            end
            ST_VSYNC: begin
                if (tmr == T_VSYNC) begin
                    state_nxt = ST_VBACK;
                    tmr_nxt   = '0;
                end
            end
            ST_VBACK: begin
                if (tmr == T_VBACK) begin
                    state_nxt = ST_ACTIVE;
                    tmr_nxt   = '0;
                    col_nxt   = '0;
                    row_nxt   = '0;
                    phase_nxt = '0;
                end
            end
            ST_ACTIVE: begin
                // Line length is set by col/phase; the timer is parked at 0
                // so HBLANK starts counting from zero.
                tmr_nxt = '0;
                if (phase == PH_LAST) begin
                    phase_nxt = '0;
                    if (col == COL_LAST) begin
                        state_nxt = ST_HBLANK;
                    end else begin
                        col_nxt = col + CW'(1);
                    end
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end
            ST_HBLANK: begin
                if (tmr == T_HBLANK) begin
                    tmr_nxt = '0;
                    col_nxt = '0;
                    if (row == ROW_LAST) begin
                        row_nxt   = '0;
                        state_nxt = ST_VFRONT;
                    end else begin
                        row_nxt   = row + CW'(1);
                        state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_VFRONT: begin
                if (tmr == T_VFRONT) begin
                    tmr_nxt   = '0;
                    frame_nxt = frame_cnt + 8'd1;
                    if (enable) begin
                        state_nxt = ST_VSYNC;
                        pat_nxt   = pat_e'(pat_sel);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tmr_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        vs_nxt   = (state_nxt == ST_VSYNC);
        href_nxt = (state_nxt == ST_ACTIVE);
        wr_nxt   = href_nxt && (phase_nxt == '0);
        data_nxt = wr_nxt ? pix : 16'h0000;
    end

endmodule

// File: tb/tb_cmos_pattern_gen.sv
// tb/tb_cmos_pattern_gen.sv - randomized self-checking bench for cmos_pattern_gen
module tb_cmos_pattern_gen;

    // Instance A: WR_EVERY = 1, wide enough to reach the ROI box corner columns.
    localparam int A_HA = 304, A_VA = 82, A_HB = 4, A_WE = 1, A_VS = 1, A_VB = 1, A_VF = 1;
    localparam int A_L  = A_HA * A_WE + A_HB;
    localparam int A_FP = (A_VS + A_VB + A_VA + A_VF) * A_L;
    // Instance B: tiny geometry with multi-clock pixel slots.
    localparam int B_HA = 16, B_VA = 4, B_HB = 3, B_WE = 3, B_VS = 2, B_VB = 1, B_VF = 1;
    localparam int B_L  = B_HA * B_WE + B_HB;
    localparam int B_FP = (B_VS + B_VB + B_VA + B_VF) * B_L;

    typedef struct packed {
        logic        vs;
        logic        href;
        logic        wr;
        logic [15:0] data;
    } pix_t;

    logic        m_pclk   = 1'b0;
    logic        s_rst_n  = 1'b0;
    logic        enable_a = 1'b0, enable_b = 1'b0;
    logic [1:0]  pat_a    = 2'd0, pat_b = 2'd0;
    logic        vs_a, href_a, wr_a, vs_b, href_b, wr_b;
    logic [15:0] data_a, data_b;
    logic [7:0]  fcnt_a, fcnt_b;
    logic [26:0] outs_a, outs_b;

    int checks = 0;
    int errors = 0;

    assign outs_a = {vs_a, href_a, wr_a, data_a, fcnt_a};
    assign outs_b = {vs_b, href_b, wr_b, data_b, fcnt_b};

    always #5 m_pclk = ~m_pclk;

    cmos_pattern_gen #(
        .H_ACTIVE(A_HA), .V_ACTIVE(A_VA), .H_BLANK(A_HB), .WR_EVERY(A_WE),
        .V_SYNC_LINES(A_VS), .V_BACK_LINES(A_VB), .V_FRONT_LINES(A_VF)
    ) dut_a (
        .m_pclk(m_pclk), .s_rst_n(s_rst_n), .enable(enable_a), .pat_sel(pat_a),
        .m_data(data_a), .m_vs(vs_a), .m_href(href_a), .m_wr_en(wr_a), .frame_cnt(fcnt_a)
    );

    cmos_pattern_gen #(
        .H_ACTIVE(B_HA), .V_ACTIVE(B_VA), .H_BLANK(B_HB), .WR_EVERY(B_WE),
        .V_SYNC_LINES(B_VS), .V_BACK_LINES(B_VB), .V_FRONT_LINES(B_VF)
    ) dut_b (
        .m_pclk(m_pclk), .s_rst_n(s_rst_n), .enable(enable_b), .pat_sel(pat_b),
        .m_data(data_b), .m_vs(vs_b), .m_href(href_b), .m_wr_en(wr_b), .frame_cnt(fcnt_b)
    );

    // Reference colour of a pixel, straight from the pattern definitions.
    function automatic logic [15:0] ref_pixel(int pat, int col, int row, int ha);
        int v;
        int bar;
        case (pat)
            0: begin
                bar = col / (ha / 8);
                case (bar)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            1: begin
                v = (col / 2) % 256;
                return 16'((v / 8) * 2048 + (v / 4) * 32 + (v / 8));
            end
            2: return (((col / 16) + (row / 16)) % 2 == 1) ? 16'hFFFF : 16'h0000;
            default: return (col >= 184 && col <= 295 && row >= 80 && row <= 191) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // Expected stream at clock t (0 = first m_vs cycle) of a frame.
    function automatic pix_t ref_out(int t, int ha, int va, int hb, int we, int vs, int vb, int pat);
        int   l;
        int   line;
        int   pos;
        pix_t e;
        l    = ha * we + hb;
        line = t / l;
        pos  = t % l;
        e    = '0;
        e.vs = (line < vs);
        if (line >= vs + vb && line < vs + vb + va && pos < ha * we) begin
            e.href = 1'b1;
            if (pos % we == 0) begin
                e.wr   = 1'b1;
                e.data = ref_pixel(pat, pos / we, line - vs - vb, ha);
            end
        end
        return e;
    endfunction

    task automatic test_reset();
        s_rst_n  = 1'b0;
        enable_a = 1'b0;
        enable_b = 1'b0;
        repeat (4) @(negedge m_pclk);
        checks++;
        if ({outs_a, outs_b} !== 54'd0) begin
            errors++;
            $display("FAIL reset_state got a=%h b=%h want 0", outs_a, outs_b);
        end
        s_rst_n = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge m_pclk);
            checks++;
            if ({outs_a, outs_b} !== 54'd0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d got a=%h b=%h want 0", i, outs_a, outs_b);
            end
        end
    endtask

    // Box frame then a random-pattern frame back to back; enable drops mid-frame 2.
    task automatic test_frames_a();
        int   pat1, pat2, drop_t, strobes, bright;
        pix_t e, o;
        int   spot_c [4] = '{184, 183, 295, 296};
        int   spot_r [4] = '{80, 80, 81, 81};
        logic [15:0] spot_v [4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        pat1    = 3;
        pat2    = $urandom_range(0, 2);
        drop_t  = A_FP + (A_VS + A_VB + 40) * A_L + $urandom_range(0, A_L - 1);
        strobes = 0;
        bright  = 0;
        @(negedge m_pclk);
        pat_a    = 2'(pat1);
        enable_a = 1'b1;
        for (int t = 0; t < 2 * A_FP; t++) begin
            @(negedge m_pclk);
            e = ref_out(t % A_FP, A_HA, A_VA, A_HB, A_WE, A_VS, A_VB, (t < A_FP) ? pat1 : pat2);
            o = {vs_a, href_a, wr_a, data_a};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL frame_a t=%0d got vs,href,wr,data=%h want %h", t, o, e);
            end
            checks++;
            if (fcnt_a !== 8'(t / A_FP)) begin
                errors++;
                $display("FAIL frame_cnt_a t=%0d got %0d want %0d", t, fcnt_a, t / A_FP);
            end
            for (int k = 0; k < 4; k++) begin
                if (t == (A_VS + A_VB + spot_r[k]) * A_L + spot_c[k] * A_WE) begin
                    checks++;
                    if (wr_a !== 1'b1 || data_a !== spot_v[k]) begin
                        errors++;
                        $display("FAIL box_pixel (%0d,%0d) got wr=%b data=%h want wr=1 data=%h",
                                 spot_c[k], spot_r[k], wr_a, data_a, spot_v[k]);
                    end
                end
            end
            if (t < A_FP && wr_a === 1'b1) begin
                strobes++;
                if (data_a === 16'hFFFF) bright++;
            end
            if (t == A_FP - 1) begin
                checks++;
                if (strobes != A_HA * A_VA) begin
                    errors++;
                    $display("FAIL strobes_per_frame got %0d want %0d", strobes, A_HA * A_VA);
                end
                checks++;
                if (bright != 112 * (A_VA - 80)) begin
                    errors++;
                    $display("FAIL box_bright_count got %0d want %0d", bright, 112 * (A_VA - 80));
                end
            end
            if (t == A_FP / 2) pat_a = 2'(pat2);
            if (t == drop_t) begin
                enable_a = 1'b0;
                pat_a    = 2'($urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge m_pclk);
            checks++;
            if (outs_a !== 27'd2) begin
                errors++;
                $display("FAIL idle_after_drop cyc=%0d got %h want %h", i, outs_a, 27'd2);
            end
        end
    endtask

    task automatic test_async_reset();
        int   pat, t_hit;
        pix_t e, o;
        pat   = $urandom_range(0, 3);
        t_hit = (A_VS + A_VB) * A_L + 250 * A_WE;
        @(negedge m_pclk);
        pat_a    = 2'(pat);
        enable_a = 1'b1;
        for (int t = 0; t <= t_hit; t++) begin
            @(negedge m_pclk);
            e = ref_out(t, A_HA, A_VA, A_HB, A_WE, A_VS, A_VB, pat);
            o = {vs_a, href_a, wr_a, data_a};
            checks++;
            if (o !== e || fcnt_a !== 8'd2) begin
                errors++;
                $display("FAIL pre_reset t=%0d got %h fc=%0d want %h fc=2", t, o, fcnt_a, e);
            end
        end
        #2 s_rst_n = 1'b0;
        #1;
        checks++;
        if (outs_a !== 27'd0) begin
            errors++;
            $display("FAIL async_reset_immediate got %h want 0", outs_a);
        end
        pat   = $urandom_range(0, 3);
        pat_a = 2'(pat);
        @(negedge m_pclk);
        @(negedge m_pclk);
        s_rst_n = 1'b1;
        for (int t = 0; t < 3 * A_L; t++) begin
            @(negedge m_pclk);
            e = ref_out(t, A_HA, A_VA, A_HB, A_WE, A_VS, A_VB, pat);
            o = {vs_a, href_a, wr_a, data_a};
            checks++;
            if (o !== e || fcnt_a !== 8'd0) begin
                errors++;
                $display("FAIL post_reset t=%0d got %h fc=%0d want %h fc=0", t, o, fcnt_a, e);
            end
        end
        enable_a = 1'b0;
    endtask

    // Multi-clock slots, bars then random pattern; pat_sel changes on the last clock of frame 1.
    task automatic test_slot_phase();
        int   pat2;
        pix_t e, o;
        int   spot_c [4] = '{0, 2, 13, 15};
        int   spot_r [4] = '{0, 0, 1, 1};
        logic [15:0] spot_v [4] = '{16'hFFFF, 16'hFFE0, 16'h001F, 16'h0000};
        pat2 = $urandom_range(0, 3);
        @(negedge m_pclk);
        pat_b    = 2'd0;
        enable_b = 1'b1;
        for (int t = 0; t < 2 * B_FP; t++) begin
            @(negedge m_pclk);
            e = ref_out(t % B_FP, B_HA, B_VA, B_HB, B_WE, B_VS, B_VB, (t < B_FP) ? 0 : pat2);
            o = {vs_b, href_b, wr_b, data_b};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL slot_b t=%0d got vs,href,wr,data=%h want %h", t, o, e);
            end
            checks++;
            if (fcnt_b !== 8'(t / B_FP)) begin
                errors++;
                $display("FAIL frame_cnt_b t=%0d got %0d want %0d", t, fcnt_b, t / B_FP);
            end
            for (int k = 0; k < 4; k++) begin
                if (t == (B_VS + B_VB + spot_r[k]) * B_L + spot_c[k] * B_WE) begin
                    checks++;
                    if (wr_b !== 1'b1 || data_b !== spot_v[k]) begin
                        errors++;
                        $display("FAIL bars_pixel (%0d,%0d) got wr=%b data=%h want wr=1 data=%h",
                                 spot_c[k], spot_r[k], wr_b, data_b, spot_v[k]);
                    end
                end
            end
            if (t == B_FP / 3) pat_b = 2'($urandom_range(0, 3));
            if (t == B_FP - 1) pat_b = 2'(pat2);
            if (t == 2 * B_FP - 1) enable_b = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge m_pclk);
            checks++;
            if (outs_b !== 27'd2) begin
                errors++;
                $display("FAIL idle_b cyc=%0d got %h want %h", i, outs_b, 27'd2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames_a();
        test_async_reset();
        test_slot_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
